// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: one outstanding instruction-memory request at a time,
// redirect handling with stale-response drain, and a valid/ready hand-off to decode.
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    output logic [1:0]      state_dbg
);

    // Handshakes: a request transfers on a rising edge where imem_req_valid and
    // imem_req_ready are both high; an instruction transfers on a rising edge where
    // inst_valid and inst_ready are both high. Valid never depends on ready.

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_target;

    // Instructions are word aligned, so the low two target bits are discarded.
    assign redirect_target = redirect_pc & ~XLEN'(3);

    assign imem_req_valid = (state == ST_FETCH) && !rst;
    assign imem_req_addr  = fetch_pc;
    assign inst_valid     = (state == ST_HOLD) && !rst;
    assign state_dbg      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            fetch_pc  <= RESET_PC;
            inst_data <= '0;
            inst_pc   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                    end
                    if (imem_req_ready) begin
                        // A request accepted alongside a redirect is already stale.
                        state <= redirect_valid ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                        state    <= imem_rsp_valid ? ST_FETCH : ST_DRAIN;
                    end else if (imem_rsp_valid) begin
                        inst_data <= imem_rsp_data;
                        inst_pc   <= fetch_pc;
                        fetch_pc  <= fetch_pc + XLEN'(4);
                        state     <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                    end
                    if (imem_rsp_valid) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    // A redirect drops the held instruction unless decode takes it this cycle.
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                        state    <= ST_FETCH;
                    end else if (inst_ready) begin
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
